// File: rtl/fifo_arb_pkg.sv
// Shared types for the fifo push arbiter: sequencer states and flush mode encodings.
package fifo_arb_pkg;
  typedef enum logic [1:0] {INIT, RUN, DISCARD, DRAIN} arb_state_e;
  localparam logic FLUSH_DISCARD = 1'b0;
  localparam logic FLUSH_DRAIN   = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr_i (with wrap) wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o
);
  logic [IW:0] cand;
  logic        found;

  // Wrap by compare so non-power-of-2 NUM_REQ never selects a phantom index.
  always_comb begin
    cand  = '0;
    found = 1'b0;
    idx_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_i} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!found && req_i[cand[IW-1:0]]) begin
        found = 1'b1;
        idx_o = cand[IW-1:0];
      end
    end
    gnt_o = found ? (NUM_REQ'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/fifo_push_arb.sv
// Round-robin push arbiter, occupancy tracker and flush sequencer for one shared fifo.
// Optional per-requester stall counters: define FIFO_PUSH_ARB_PERF_CNT_EN.
module fifo_push_arb
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 8,
  localparam int IW = $clog2(NUM_REQ),
  localparam int OW = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          flush_req,
  input  logic                          flush_mode,
  output logic                          flush_done,
  output logic                          fifo_push,
  output logic [DATA_WIDTH-1:0]         fifo_push_data,
  output logic                          fifo_reset,
  input  logic                          fifo_pop,
  input  logic                          fifo_full,
  input  logic                          fifo_empty,
  output logic [OW-1:0]                 occupancy
`ifdef FIFO_PUSH_ARB_PERF_CNT_EN
  ,
  output logic [NUM_REQ*32-1:0]         stall_cnt
`endif
);
  arb_state_e state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          done_q, done_d;

  logic [NUM_REQ-1:0]                 gnt;
  logic [IW-1:0]                      gnt_idx;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data_a;
  logic                               can_push, pop_eff;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  // flush_req gates ready in the same cycle so no push races the flush.
  assign can_push       = (state_q == RUN) && !fifo_full && !flush_req;
  assign req_ready      = can_push ? gnt : '0;
  assign fifo_push      = |(req_valid & req_ready);
  assign req_data_a     = req_data;
  assign fifo_push_data = fifo_push ? req_data_a[gnt_idx] : '0;
  assign pop_eff        = fifo_pop && !fifo_empty;
  assign occupancy      = occ_q;
  assign flush_done     = done_q;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    occ_d      = occ_q;
    done_d     = 1'b0;
    fifo_reset = 1'b0;
    if (fifo_push)
      rr_ptr_d = (gnt_idx == IW'(NUM_REQ-1)) ? '0 : gnt_idx + IW'(1);
    case (state_q)
      INIT: begin
        fifo_reset = 1'b1;
        occ_d      = '0;
        state_d    = RUN;
      end
      RUN: begin
        occ_d = occ_q + OW'(fifo_push) - OW'(pop_eff);
        if (flush_req) begin
          case (flush_mode)
            FLUSH_DISCARD: state_d = DISCARD;
            FLUSH_DRAIN:   state_d = DRAIN;
          endcase
        end
      end
      DISCARD: begin
        fifo_reset = 1'b1;
        occ_d      = '0;
        done_d     = 1'b1;
        state_d    = RUN;
      end
      DRAIN: begin
        if (occ_q == '0) begin
          done_d  = 1'b1;
          state_d = RUN;
        end else begin
          occ_d = occ_q - OW'(pop_eff);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= INIT;
      rr_ptr_q <= '0;
      occ_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      occ_q    <= occ_d;
      done_q   <= done_d;
    end
  end

`ifdef FIFO_PUSH_ARB_PERF_CNT_EN
  logic [31:0] stall_q [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stall
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        stall_q[i] <= '0;
      else if (state_q == RUN && req_valid[i] && !req_ready[i] && stall_q[i] != '1)
        stall_q[i] <= stall_q[i] + 32'd1;
    end
    assign stall_cnt[i*32 +: 32] = stall_q[i];
  end
`endif
endmodule

// File: tb/tb_fifo_push_arb.sv
// Directed bench for fifo_push_arb with a queue-level reference model and fifo stand-in.
module tb_fifo_push_arb;
  localparam int N     = 4;
  localparam int DW    = 128;
  localparam int DEPTH = 8;
  localparam int M_INIT = 0, M_RUN = 1, M_DISCARD = 2, M_DRAIN = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            flush_req = 1'b0;
  logic            flush_mode = 1'b0;
  logic            flush_done;
  logic            fifo_push;
  logic [DW-1:0]   fifo_push_data;
  logic            fifo_reset;
  logic            fifo_pop = 1'b0;
  logic            fifo_full, fifo_empty;
  logic [2:0]      occupancy;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: fifo entry count, rr pointer, sequencer phase.
  int m_st = M_INIT, m_ptr = 0, m_cnt = 0;
  bit m_done = 1'b0;

  assign fifo_full  = (m_cnt == DEPTH-1);
  assign fifo_empty = (m_cnt == 0);

  fifo_push_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .flush_req(flush_req), .flush_mode(flush_mode),
    .flush_done(flush_done), .fifo_push(fifo_push), .fifo_push_data(fifo_push_data),
    .fifo_reset(fifo_reset), .fifo_pop(fifo_pop), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Which producer the rules say gets the slot this cycle, -1 for none.
  function automatic int grant_idx();
    if (m_st != M_RUN || m_cnt == DEPTH-1 || flush_req) return -1;
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  int u_g, u_cnt, u_ptr, u_st;
  bit u_done, u_pop;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_st <= M_INIT; m_ptr <= 0; m_cnt <= 0; m_done <= 1'b0;
    end else begin
      u_g = grant_idx(); u_cnt = m_cnt; u_ptr = m_ptr; u_st = m_st; u_done = 1'b0;
      u_pop = fifo_pop && (m_cnt > 0);
      case (m_st)
        M_INIT: begin u_cnt = 0; u_st = M_RUN; end
        M_RUN: begin
          if (u_g >= 0) begin u_ptr = (u_g + 1) % N; u_cnt++; end
          if (u_pop) u_cnt--;
          if (flush_req) u_st = flush_mode ? M_DRAIN : M_DISCARD;
        end
        M_DISCARD: begin u_cnt = 0; u_done = 1'b1; u_st = M_RUN; end
        default: begin
          if (m_cnt == 0) begin u_done = 1'b1; u_st = M_RUN; end
          else if (u_pop) u_cnt--;
        end
      endcase
      m_st <= u_st; m_ptr <= u_ptr; m_cnt <= u_cnt; m_done <= u_done;
    end
  end

  int c_g;
  logic [N-1:0]  c_ready;
  logic [DW-1:0] c_data;
  always @(negedge clk) begin
    if (rst) begin
      c_g     = grant_idx();
      c_ready = (c_g >= 0) ? N'(1 << c_g) : '0;
      c_data  = (c_g >= 0) ? req_data[c_g*DW +: DW] : '0;
      chk("m_ready", 32'(req_ready), 32'(c_ready));
      chk("m_push", 32'(fifo_push), 32'(c_g >= 0));
      chkd("m_data", fifo_push_data, c_data);
      chk("m_reset", 32'(fifo_reset), 32'(m_st == M_INIT || m_st == M_DISCARD));
      chk("m_occ", 32'(occupancy), 32'(m_cnt));
      chk("m_done", 32'(flush_done), 32'(m_done));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  logic [3:0] exp4 [6] = '{4'b1000, 4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0010};
  logic [3:0] exp3 [3] = '{4'b1000, 4'b0001, 4'b0010};

  initial begin
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = {4{32'(i + 1) * 32'h1111_1111}};
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; req_valid = 4'hF;
    #2;
    chk("init_reset", 32'(fifo_reset), 32'd1);
    chk("init_ready", 32'(req_ready), 32'd0);
    chk("init_occ", 32'(occupancy), 32'd0);
    tick();
    // All producers valid, no pops: strict rotation until full.
    for (int k = 0; k < 7; k++) begin
      #2;
      chk("rr_all", 32'(req_ready), 32'(1 << (k % 4)));
      if (k == 0) begin
        chk("run_reset", 32'(fifo_reset), 32'd0);
        chkd("push_data0", fifo_push_data, {4{32'h1111_1111}});
      end
      tick();
    end
    #2;
    chk("full_ready", 32'(req_ready), 32'd0);
    chk("full_occ", 32'(occupancy), 32'd7);
    chk("full_push", 32'(fifo_push), 32'd0);
    req_valid = '0; fifo_pop = 1'b1;
    tick(); tick();
    // Push and pop together keep the count at 5.
    req_valid = 4'hF;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("pp_ready", 32'(req_ready), 32'(exp3[k]));
      chk("pp_occ", 32'(occupancy), 32'd5);
      tick();
    end
    req_valid = '0;
    tick();
    fifo_pop = 1'b0;
    // Sparse requesters, then a stalled req 1 under full keeps its turn.
    req_valid = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      fifo_pop = (k == 4);
      #2;
      chk("rr_1010", 32'(req_ready), 32'(exp4[k]));
      tick();
    end
    req_valid = '0; fifo_pop = 1'b1;
    tick(); tick(); tick();
    fifo_pop = 1'b0;
    // Discard flush from occupancy 4.
    req_valid = 4'hF; flush_req = 1'b1; flush_mode = 1'b0;
    #2;
    chk("dis_ready0", 32'(req_ready), 32'd0);
    chk("dis_push0", 32'(fifo_push), 32'd0);
    chk("dis_occ0", 32'(occupancy), 32'd4);
    tick();
    flush_req = 1'b0;
    #2;
    chk("dis_reset", 32'(fifo_reset), 32'd1);
    chk("dis_ready1", 32'(req_ready), 32'd0);
    chk("dis_done_early", 32'(flush_done), 32'd0);
    tick();
    req_valid = '0;
    #2;
    chk("dis_done", 32'(flush_done), 32'd1);
    chk("dis_occ", 32'(occupancy), 32'd0);
    chk("dis_reset_off", 32'(fifo_reset), 32'd0);
    tick();
    #2 chk("dis_done_pulse", 32'(flush_done), 32'd0);
    fifo_pop = 1'b1;
    tick();
    fifo_pop = 1'b0;
    #2 chk("empty_pop_occ", 32'(occupancy), 32'd0);
    // Drain flush from occupancy 3, pops every other cycle.
    req_valid = 4'b0100;
    tick(); tick(); tick();
    req_valid = 4'hF;
    #2 chk("drn_occ0", 32'(occupancy), 32'd3);
    flush_req = 1'b1; flush_mode = 1'b1;
    #1 chk("drn_ready0", 32'(req_ready), 32'd0);
    tick();
    flush_req = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      fifo_pop = (e % 2 == 1);
      #2;
      chk("drn_ready", 32'(req_ready), 32'd0);
      chk("drn_done_early", 32'(flush_done), 32'd0);
      tick();
    end
    fifo_pop = 1'b0; req_valid = '0;
    #2;
    chk("drn_done", 32'(flush_done), 32'd1);
    chk("drn_occ", 32'(occupancy), 32'd0);
    tick();
    #2 chk("drn_done_pulse", 32'(flush_done), 32'd0);
    // Async reset in the middle of a drain.
    req_valid = 4'b1000;
    tick(); tick();
    req_valid = '0; flush_req = 1'b1; flush_mode = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
    req_valid = 4'hF; rst = 1'b0;
    #2;
    chk("arst_reset", 32'(fifo_reset), 32'd1);
    chk("arst_occ", 32'(occupancy), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    chk("arst_done", 32'(flush_done), 32'd0);
    tick();
    rst = 1'b1;
    #2 chk("arst_init", 32'(fifo_reset), 32'd1);
    tick();
    #2;
    chk("arst_run", 32'(fifo_reset), 32'd0);
    chk("arst_grant", 32'(req_ready), 32'd1);
    req_valid = '0;
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
